// File: rtl/spu32_cpu_alu_arbiter_pkg.sv
// Shared definitions for the spu32 ALU arbiter: ALUOP codes, arbiter states, port ids.
package spu32_cpu_alu_arbiter_pkg;

    localparam logic [3:0] ALUOP_ADD = 4'b0000;
    localparam logic [3:0] ALUOP_SUB = 4'b1000;
    localparam logic [3:0] ALUOP_AND = 4'b0111;
    localparam logic [3:0] ALUOP_OR  = 4'b0110;
    localparam logic [3:0] ALUOP_XOR = 4'b0100;
    localparam logic [3:0] ALUOP_MUL = 4'b1010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StWait = 2'd2,
        StResp = 2'd3
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/spu32_cpu_rr_arbiter2.sv
// Two-input round-robin grant; the priority pointer moves to the other port on accept.
module spu32_cpu_rr_arbiter2
    import spu32_cpu_alu_arbiter_pkg::*;
(
    input  logic I_clk,
    input  logic I_reset_n,
    input  logic I_valid0,
    input  logic I_valid1,
    input  logic I_accept,
    output logic O_grant_valid,
    output logic O_grant_id
);

    // Port favoured when both requesters are valid.
    logic prio_q;

    always_comb begin
        O_grant_valid = I_valid0 | I_valid1;
        if (I_valid0 && I_valid1) begin
            O_grant_id = prio_q;
        end else begin
            O_grant_id = I_valid1 ? PORT1 : PORT0;
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            prio_q <= PORT0;
        end else if (I_accept) begin
            prio_q <= ~O_grant_id;
        end
    end

endmodule

// File: rtl/spu32_cpu_alu_arbiter.sv
// Shares one spu32 ALU between two requesters, one operation outstanding at a time.
// Optional WAIT timeout with ALU reset is enabled by defining ALU_ARB_TIMEOUT_EN.
module spu32_cpu_alu_arbiter
    import spu32_cpu_alu_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_req0_valid,
    input  logic        I_req1_valid,
    output logic        O_req0_ready,
    output logic        O_req1_ready,
    input  logic [3:0]  I_req0_aluop,
    input  logic [3:0]  I_req1_aluop,
    input  logic [31:0] I_req0_s1,
    input  logic [31:0] I_req0_s2,
    input  logic [31:0] I_req1_s1,
    input  logic [31:0] I_req1_s2,
    output logic        O_rsp0_valid,
    output logic        O_rsp1_valid,
    input  logic        I_rsp0_ready,
    input  logic        I_rsp1_ready,
    output logic [31:0] O_rsp_data,
    output logic        O_rsp_lt,
    output logic        O_rsp_ltu,
    output logic        O_rsp_eq,
    output logic        O_rsp_err,
    output logic        O_alu_en,
    output logic        O_alu_reset,
    output logic [3:0]  O_alu_aluop,
    output logic [31:0] O_alu_s1,
    output logic [31:0] O_alu_s2,
    input  logic        I_alu_busy,
    input  logic [31:0] I_alu_data,
    input  logic        I_alu_lt,
    input  logic        I_alu_ltu,
    input  logic        I_alu_eq,
    output logic        O_busy
);

    arb_state_e  state_q, state_d;
    logic        gnt_valid, gnt_id, accept, timeout, rsp_ready;
    logic        id_q;
    logic [3:0]  op_q;
    logic [31:0] s1_q, s2_q, data_q, data_d;
    logic        lt_q, ltu_q, eq_q;

    spu32_cpu_rr_arbiter2 u_rr (
        .I_clk         (I_clk),
        .I_reset_n     (I_reset_n),
        .I_valid0      (I_req0_valid),
        .I_valid1      (I_req1_valid),
        .I_accept      (accept),
        .O_grant_valid (gnt_valid),
        .O_grant_id    (gnt_id)
    );

    assign accept       = (state_q == StIdle) && gnt_valid;
    assign O_req0_ready = accept && (gnt_id == PORT0);
    assign O_req1_ready = accept && (gnt_id == PORT1);
    assign rsp_ready    = (id_q == PORT1) ? I_rsp1_ready : I_rsp0_ready;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        O_alu_en = 1'b0;
        unique case (state_q)
            StIdle: if (accept) state_d = StExec;
            StExec: begin
                O_alu_en = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                // Timeout wins over busy so the hung ALU is not re-enabled while being reset.
                if (timeout) begin
                    data_d  = '0;
                    state_d = StResp;
                end else if (I_alu_busy) begin
                    O_alu_en = 1'b1;
                end else begin
                    data_d  = I_alu_data;
                    state_d = StResp;
                end
            end
            StResp: if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            id_q    <= PORT0;
            op_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            if (accept) begin
                id_q <= gnt_id;
                op_q <= (gnt_id == PORT1) ? I_req1_aluop : I_req0_aluop;
                s1_q <= (gnt_id == PORT1) ? I_req1_s1 : I_req0_s1;
                s2_q <= (gnt_id == PORT1) ? I_req1_s2 : I_req0_s2;
            end
            if (state_q == StExec) begin
                lt_q  <= I_alu_lt;
                ltu_q <= I_alu_ltu;
                eq_q  <= I_alu_eq;
            end
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    assign timeout     = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES));
    assign O_alu_reset = timeout;
    assign O_rsp_err   = err_q;

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == StExec) begin
                cnt_q <= '0;
            end else if ((state_q == StWait) && I_alu_busy && !timeout) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout     = 1'b0;
    assign O_alu_reset = 1'b0;
    assign O_rsp_err   = 1'b0;
`endif

    assign O_rsp0_valid = (state_q == StResp) && (id_q == PORT0);
    assign O_rsp1_valid = (state_q == StResp) && (id_q == PORT1);
    assign O_rsp_data   = data_q;
    assign O_rsp_lt     = lt_q;
    assign O_rsp_ltu    = ltu_q;
    assign O_rsp_eq     = eq_q;
    assign O_alu_aluop  = op_q;
    assign O_alu_s1     = s1_q;
    assign O_alu_s2     = s2_q;
    assign O_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_spu32_cpu_alu_arbiter.sv
// Self-checking bench for spu32_cpu_alu_arbiter with a behavioural ALU; timeout case needs
// ALU_ARB_TIMEOUT_EN.
module tb_spu32_cpu_alu_arbiter;
    import spu32_cpu_alu_arbiter_pkg::*;

    localparam int unsigned TO = 8;

    logic        I_clk = 1'b0;
    logic        I_reset_n;
    logic        I_req0_valid, I_req1_valid, O_req0_ready, O_req1_ready;
    logic [3:0]  I_req0_aluop, I_req1_aluop;
    logic [31:0] I_req0_s1, I_req0_s2, I_req1_s1, I_req1_s2;
    logic        O_rsp0_valid, O_rsp1_valid, I_rsp0_ready, I_rsp1_ready;
    logic [31:0] O_rsp_data;
    logic        O_rsp_lt, O_rsp_ltu, O_rsp_eq, O_rsp_err;
    logic        O_alu_en, O_alu_reset;
    logic [3:0]  O_alu_aluop;
    logic [31:0] O_alu_s1, O_alu_s2;
    logic        I_alu_busy;
    logic [31:0] I_alu_data;
    logic        I_alu_lt, I_alu_ltu, I_alu_eq;
    logic        O_busy;

    int checks = 0;
    int errors = 0;

    spu32_cpu_alu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .I_clk(I_clk), .I_reset_n(I_reset_n),
        .I_req0_valid(I_req0_valid), .I_req1_valid(I_req1_valid),
        .O_req0_ready(O_req0_ready), .O_req1_ready(O_req1_ready),
        .I_req0_aluop(I_req0_aluop), .I_req1_aluop(I_req1_aluop),
        .I_req0_s1(I_req0_s1), .I_req0_s2(I_req0_s2),
        .I_req1_s1(I_req1_s1), .I_req1_s2(I_req1_s2),
        .O_rsp0_valid(O_rsp0_valid), .O_rsp1_valid(O_rsp1_valid),
        .I_rsp0_ready(I_rsp0_ready), .I_rsp1_ready(I_rsp1_ready),
        .O_rsp_data(O_rsp_data), .O_rsp_lt(O_rsp_lt), .O_rsp_ltu(O_rsp_ltu),
        .O_rsp_eq(O_rsp_eq), .O_rsp_err(O_rsp_err),
        .O_alu_en(O_alu_en), .O_alu_reset(O_alu_reset), .O_alu_aluop(O_alu_aluop),
        .O_alu_s1(O_alu_s1), .O_alu_s2(O_alu_s2),
        .I_alu_busy(I_alu_busy), .I_alu_data(I_alu_data),
        .I_alu_lt(I_alu_lt), .I_alu_ltu(I_alu_ltu), .I_alu_eq(I_alu_eq),
        .O_busy(O_busy)
    );

    always #5 I_clk = ~I_clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            ALUOP_ADD: return a + b;
            ALUOP_SUB: return a - b;
            ALUOP_AND: return a & b;
            ALUOP_OR:  return a | b;
            ALUOP_XOR: return a ^ b;
            ALUOP_MUL: return a * b;
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [2:0] flags_ref(input logic [31:0] a, input logic [31:0] b);
        return {$signed(a) < $signed(b), a < b, a == b};
    endfunction

    // Behavioural ALU: MUL raises busy for mul_lat cycles after its first enable.
    int   mul_lat = 0;
    logic alu_stuck = 1'b0;
    int   busy_cnt;
    logic en_mid = 1'b0;
    logic [3:0] op_mid = '0;

    assign I_alu_data = alu_ref(O_alu_aluop, O_alu_s1, O_alu_s2);
    assign {I_alu_lt, I_alu_ltu, I_alu_eq} = flags_ref(O_alu_s1, O_alu_s2);
    assign I_alu_busy = alu_stuck | (busy_cnt != 0);

    always @(negedge I_clk) begin
        en_mid <= O_alu_en;
        op_mid <= O_alu_aluop;
    end

    always @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) busy_cnt <= 0;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (en_mid && op_mid == ALUOP_MUL) busy_cnt <= mul_lat;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for a grant, follows the op to its response, optionally back-pressures, consumes.
    task automatic run_txn(input int port, input logic [31:0] dexp, input logic [2:0] fexp,
                           input int lat_exp, input int hold, input logic [1:0] after,
                           input string name);
        int t, lat, en_cnt;
        logic [31:0] d0;
        t = 0;
        #1;
        while (!(O_req0_ready || O_req1_ready) && t < 50) begin
            @(negedge I_clk); #1; t++;
        end
        chk($sformatf("%s_grant", name), {O_req1_ready, O_req0_ready},
            (port == 0) ? 2'b01 : 2'b10);
        if (!(O_req0_ready || O_req1_ready)) return;
        @(negedge I_clk);
        {I_req1_valid, I_req0_valid} = after;
        #1;
        lat = 1;
        en_cnt = 0;
        while (!(O_rsp0_valid || O_rsp1_valid) && lat < 200) begin
            if (O_alu_en) en_cnt++;
            @(negedge I_clk); #1; lat++;
        end
        chk($sformatf("%s_latency", name), lat, lat_exp);
        chk($sformatf("%s_en_cycles", name), en_cnt, lat_exp - 2);
        chk($sformatf("%s_rsp_port", name), {O_rsp1_valid, O_rsp0_valid},
            (port == 0) ? 2'b01 : 2'b10);
        chk($sformatf("%s_data", name), O_rsp_data, dexp);
        chk($sformatf("%s_flags", name), {O_rsp_lt, O_rsp_ltu, O_rsp_eq}, fexp);
        chk($sformatf("%s_err", name), O_rsp_err, 1'b0);
        d0 = O_rsp_data;
        repeat (hold) begin
            @(negedge I_clk); #1;
            chk($sformatf("%s_hold_valid", name), {O_rsp1_valid, O_rsp0_valid},
                (port == 0) ? 2'b01 : 2'b10);
            chk($sformatf("%s_hold_data", name), O_rsp_data, d0);
            chk($sformatf("%s_hold_noready", name), {O_req1_ready, O_req0_ready}, 2'b00);
        end
        if (port == 0) I_rsp0_ready = 1'b1;
        else I_rsp1_ready = 1'b1;
        @(negedge I_clk);
        I_rsp0_ready = 1'b0;
        I_rsp1_ready = 1'b0;
        #1;
        chk($sformatf("%s_idle_after", name), O_busy, 1'b0);
    endtask

    typedef struct {
        int          port;
        logic [3:0]  op;
        logic [31:0] s1, s2;
        int          lat;
        logic [31:0] data;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int prio, port, lat, k, rst_at, rst_seen;
        logic [3:0] op;
        logic [31:0] a, b;

        vecs[0] = '{0, ALUOP_ADD, 32'd5, 32'd7, 0, 32'd12, 3'b110};
        vecs[1] = '{1, ALUOP_SUB, 32'd3, 32'd10, 0, 32'hFFFF_FFF9, 3'b110};
        vecs[2] = '{0, ALUOP_MUL, 32'hFFFF_FFFF, 32'd2, 4, 32'hFFFF_FFFE, 3'b100};
        vecs[3] = '{1, ALUOP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 32'h5A5A_A5A5, 3'b110};
        vecs[4] = '{0, ALUOP_AND, 32'h8000_0000, 32'h7FFF_FFFF, 0, 32'h0, 3'b100};
        vecs[5] = '{1, ALUOP_OR, 32'h1234, 32'h1234, 0, 32'h1234, 3'b001};

        I_reset_n = 1'b0;
        {I_req0_valid, I_req1_valid, I_rsp0_ready, I_rsp1_ready} = '0;
        {I_req0_aluop, I_req1_aluop} = '0;
        {I_req0_s1, I_req0_s2, I_req1_s1, I_req1_s2} = '0;

        @(negedge I_clk); #1;
        chk("reset_busy", O_busy, 1'b0);
        chk("reset_en", O_alu_en, 1'b0);
        chk("reset_alu_reset", O_alu_reset, 1'b0);
        chk("reset_rsp_valid", {O_rsp1_valid, O_rsp0_valid}, 2'b00);
        chk("reset_err", O_rsp_err, 1'b0);
        chk("reset_data", O_rsp_data, 32'h0);
        chk("reset_operands", {O_alu_aluop, O_alu_s1, O_alu_s2}, '0);
        @(negedge I_clk);
        I_reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge I_clk);
            mul_lat = vecs[i].lat;
            if (vecs[i].port == 0) begin
                I_req0_aluop = vecs[i].op; I_req0_s1 = vecs[i].s1; I_req0_s2 = vecs[i].s2;
                I_req0_valid = 1'b1;
            end else begin
                I_req1_aluop = vecs[i].op; I_req1_s1 = vecs[i].s1; I_req1_s2 = vecs[i].s2;
                I_req1_valid = 1'b1;
            end
            run_txn(vecs[i].port, vecs[i].data, vecs[i].flags, 3 + vecs[i].lat, 0, 2'b00,
                    $sformatf("vec%0d", i));
        end

        // Round-robin from a fresh reset with both requesters held valid.
        @(negedge I_clk); I_reset_n = 1'b0;
        @(negedge I_clk); I_reset_n = 1'b1;
        I_req0_aluop = ALUOP_ADD; I_req0_s1 = 32'd1;  I_req0_s2 = 32'd1;
        I_req1_aluop = ALUOP_ADD; I_req1_s1 = 32'd10; I_req1_s2 = 32'd20;
        I_req0_valid = 1'b1; I_req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_txn(i % 2, (i % 2 != 0) ? 32'd30 : 32'd2, (i % 2 != 0) ? 3'b110 : 3'b001,
                    3, 0, 2'b11, $sformatf("rr%0d", i));
        end
        I_req0_valid = 1'b0; I_req1_valid = 1'b0;

        // Port 1 response held 10 cycles while port 0 waits.
        @(negedge I_clk);
        I_req0_aluop = ALUOP_ADD; I_req0_s1 = 32'd5;   I_req0_s2 = 32'd7;
        I_req1_aluop = ALUOP_SUB; I_req1_s1 = 32'd100; I_req1_s2 = 32'd1;
        I_req1_valid = 1'b1;
        run_txn(1, 32'd99, 3'b000, 3, 10, 2'b01, "bp");
        run_txn(0, 32'd12, 3'b110, 3, 0, 2'b00, "bp_next");

        // Async reset while a multiply is busy in WAIT.
        @(negedge I_clk);
        mul_lat = 4;
        I_req0_aluop = ALUOP_MUL; I_req0_s1 = 32'd6; I_req0_s2 = 32'd7;
        I_req0_valid = 1'b1;
        #1;
        chk("rstwait_grant", O_req0_ready, 1'b1);
        @(negedge I_clk); I_req0_valid = 1'b0;
        repeat (2) @(negedge I_clk);
        #1;
        chk("rstwait_inwait_busy", {O_busy, I_alu_busy}, 2'b11);
        I_reset_n = 1'b0;
        #1;
        chk("rstwait_busy", O_busy, 1'b0);
        chk("rstwait_en", O_alu_en, 1'b0);
        chk("rstwait_rsp", {O_rsp1_valid, O_rsp0_valid}, 2'b00);
        chk("rstwait_operands", {O_alu_aluop, O_alu_s1, O_alu_s2}, '0);
        chk("rstwait_data", O_rsp_data, 32'h0);
        @(negedge I_clk); I_reset_n = 1'b1;
        k = 0;
        repeat (8) begin
            @(negedge I_clk); #1;
            if (O_rsp0_valid || O_rsp1_valid || O_busy) k++;
        end
        chk("rstwait_no_rsp", k, 0);
        I_req0_aluop = ALUOP_ADD; I_req0_s1 = 32'd5; I_req0_s2 = 32'd7;
        I_req0_valid = 1'b1;
        run_txn(0, 32'd12, 3'b110, 3, 0, 2'b00, "rstwait_next");

        // Randomized traffic against a transaction-level round-robin model.
        @(negedge I_clk); I_reset_n = 1'b0;
        @(negedge I_clk); I_reset_n = 1'b1;
        prio = 0;
        for (int it = 0; it < 40; it++) begin
            logic [3:0] ops[6];
            logic [1:0] v;
            ops = '{ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR, ALUOP_XOR, ALUOP_MUL};
            @(negedge I_clk);
            v = 2'($urandom_range(1, 3));
            I_req0_aluop = ops[$urandom_range(0, 5)];
            I_req1_aluop = ops[$urandom_range(0, 5)];
            I_req0_s1 = $urandom; I_req0_s2 = ($urandom_range(0, 3) == 0) ? I_req0_s1 : $urandom;
            I_req1_s1 = $urandom; I_req1_s2 = ($urandom_range(0, 3) == 0) ? I_req1_s1 : $urandom;
            lat = $urandom_range(1, 5);
            mul_lat = lat;
            port = (v == 2'b11) ? prio : ((v == 2'b01) ? 0 : 1);
            prio = 1 - port;
            op = (port == 0) ? I_req0_aluop : I_req1_aluop;
            a  = (port == 0) ? I_req0_s1 : I_req1_s1;
            b  = (port == 0) ? I_req0_s2 : I_req1_s2;
            {I_req1_valid, I_req0_valid} = v;
            run_txn(port, alu_ref(op, a, b), flags_ref(a, b),
                    3 + ((op == ALUOP_MUL) ? lat : 0), $urandom_range(0, 3), 2'b00,
                    $sformatf("rand%0d", it));
        end

`ifdef ALU_ARB_TIMEOUT_EN
        // Busy stuck high: abort after TO busy WAIT cycles.
        @(negedge I_clk);
        alu_stuck = 1'b1;
        I_req0_aluop = ALUOP_MUL; I_req0_s1 = 32'd3; I_req0_s2 = 32'd4;
        I_req0_valid = 1'b1;
        #1;
        chk("to_grant", O_req0_ready, 1'b1);
        @(negedge I_clk); I_req0_valid = 1'b0;
        k = 1; rst_at = -1; rst_seen = 0;
        #1;
        while (!O_rsp0_valid && k < 100) begin
            if (O_alu_reset) begin
                rst_seen++;
                rst_at = k;
                chk("to_en_low", O_alu_en, 1'b0);
            end
            @(negedge I_clk); #1; k++;
        end
        chk("to_reset_pulses", rst_seen, 1);
        chk("to_reset_cycle", rst_at, 2 + TO);
        chk("to_rsp_valid", O_rsp0_valid, 1'b1);
        chk("to_err", O_rsp_err, 1'b1);
        chk("to_data", O_rsp_data, 32'h0);
        alu_stuck = 1'b0;
        I_rsp0_ready = 1'b1;
        @(negedge I_clk); I_rsp0_ready = 1'b0;
        I_req0_aluop = ALUOP_ADD; I_req0_s1 = 32'd5; I_req0_s2 = 32'd7;
        I_req0_valid = 1'b1;
        run_txn(0, 32'd12, 3'b110, 3, 0, 2'b00, "to_next");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/spu32_cpu_alu_arbiter.md
Name: spu32_cpu_alu_arbiter

Overview:
- Shares one spu32 ALU instance between two requesters: port 0 (CPU execute stage) and port 1 (coprocessor/debug unit).
- Arbitrates round-robin, latches operands, and sequences the ALU enable across multi-cycle (multiply) operations using ALU busy.
- Captures result and compare flags, then returns a per-requester response.
- Sits between the requesters and the ALU; one operation is outstanding at a time.

Parameters:
- TIMEOUT_CYCLES, 64, maximum WAIT cycles with ALU busy before abort (used only with the optional feature).

Ports:
- I_clk  in  1  clock.
- I_reset_n  in  1  asynchronous active-low reset.
- I_req0_valid / I_req1_valid  in  1  request valid.
- O_req0_ready / O_req1_ready  out  1  request accepted this cycle when valid&ready.
- I_req0_aluop / I_req1_aluop  in  4  ALUOP code.
- I_req0_s1, I_req0_s2 / I_req1_s1, I_req1_s2  in  32  operands.
- O_rsp0_valid / O_rsp1_valid  out  1  response valid for that requester.
- I_rsp0_ready / I_rsp1_ready  in  1  response consumed.
- O_rsp_data  out  32  result.
- O_rsp_lt, O_rsp_ltu, O_rsp_eq  out  1  compare flags of latched operands.
- O_rsp_err  out  1  timeout abort (0 when the feature is off).
- O_alu_en  out  1  ALU I_en.
- O_alu_reset  out  1  ALU I_reset (sync, active-high).
- O_alu_aluop  out  4  latched op.
- O_alu_s1, O_alu_s2  out  32  latched operands.
- I_alu_busy  in  1  ALU O_busy.
- I_alu_data  in  32  ALU O_data.
- I_alu_lt, I_alu_ltu, I_alu_eq  in  1  ALU flags.
- O_busy  out  1  state != IDLE.

Behaviour:
- Reset (async, I_reset_n=0):
  - State IDLE; all valid, ready, err and en outputs 0; O_alu_reset 0.
  - Latched op/operands/result/flags cleared to 0.
  - Round-robin pointer favours port 0.
- States: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - Grant port 0 if only req0 is valid, port 1 if only req1 is valid.
  - If both are valid, grant the port not granted last.
  - O_reqN_ready=1 only for the granted port (combinational from the valids).
  - On transfer, latch aluop/s1/s2 and the grant id, update the pointer, go EXEC.
- EXEC (exactly 1 cycle):
  - O_alu_en=1 with latched op/operands.
  - Capture I_alu_lt/ltu/eq (combinational from operands).
  - Go WAIT.
- WAIT:
  - O_alu_en = I_alu_busy, combinational, so a multiply stays enabled until done.
  - While I_alu_busy=1, remain in WAIT.
  - When I_alu_busy=0, capture I_alu_data into O_rsp_data and go RESP.
  - Single-cycle ops therefore take 1 WAIT cycle. Request accept to rsp_valid = 3 cycles minimum.
- ALU contract: any multi-cycle op asserts busy in the cycle after its first enable.
- RESP:
  - O_rspN_valid=1 for the granted port only; data and flags held stable.
  - When I_rspN_ready=1, go IDLE.
  - A new grant is possible the cycle after return to IDLE; no accept in the RESP cycle.
- O_alu_aluop/s1/s2 change only on accept; they are stable through EXEC/WAIT/RESP.
- A requester dropping valid after accept has no effect.
- A response held indefinitely blocks both ports; the other port's ready stays 0.
- Reset mid-operation aborts immediately; no response is issued.

Optional Feature:
- Macro ALU_ARB_TIMEOUT_EN.
- Enabled:
  - A counter of consecutive WAIT cycles with busy, cleared on entering WAIT.
  - When it reaches TIMEOUT_CYCLES: O_alu_reset=1 for one cycle, O_alu_en=0, O_rsp_data=0, O_rsp_err=1, go RESP.
  - O_rsp_err is cleared on the next accept.
- Disabled:
  - No counter; O_alu_reset tied 0; O_rsp_err tied 0; WAIT waits indefinitely.

Decomposition:
- Shared package/header (aludefs): ALUOP codes (existing), arbiter state encodings, port-id constants.
- One natural sub-module: spu32_cpu_rr_arbiter2, a two-input round-robin grant with pointer update on accept.
- FSM, operand latches and response register stay in the top.

Test Plan:
- Port 0, ADD 5+7, single cycle:
  - ready same cycle; O_alu_en for 1 cycle.
  - rsp0_valid 3 cycles after accept, data 12, lt=1, ltu=1, eq=0.
- Both valid, back-to-back:
  - After reset, port 0 is granted first, port 1 next.
  - With both still valid afterwards, grants alternate 0,1,0,1.
- MUL 0xFFFFFFFF*2, busy high 4 cycles:
  - O_alu_en high through EXEC and the busy cycles.
  - Result 0xFFFFFFFE; err=0.
- Response backpressure:
  - Hold I_rsp1_ready=0 for 10 cycles; data stays stable and req0 ready stays 0.
  - Release: IDLE next cycle.
- Async reset asserted in WAIT:
  - All outputs are 0 immediately; no rsp_valid is issued.
  - The next request from port 0 completes normally.
- ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, busy stuck high:
  - O_alu_reset pulses once after 8 WAIT cycles.
  - rsp_valid with err=1, data 0.
